mul_sequencer: RTL
==================

# mul_sequencer

Control FSM for the signed 8×8 shift-add multiplier datapath, driven by the board push-buttons. It latches operands, issues one add/subtract/hold and one shift step per multiplier bit, and latches the 16-bit result. It then holds the seven-segment display for a minimum time before a clear is accepted. It sits between the button inputs and the datapath, and drives the display-enable seen by the seven-segment driver.

## Interface
- `N_BITS`, 8, operand width = number of iterations (≥2)
- `HOLD_CYCLES`, 200, minimum cycles the result stays displayed before clear is accepted (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; one clock, reset synchronous active-high
- `button`  in  4  raw levels: [0] start, [1] clear, [2] unused, [3] abort
- `mult_bit`  in  1  current LSB of the datapath multiplier shift register
- `load_inputs`  out  1  capture A/B into operand registers
- `clr`  out  1  clear accumulator/product register
- `sel`  out  2  datapath op: 00 hold, 01 add multiplicand, 10 shift, 11 subtract multiplicand
- `inc`  out  1  shift/iteration strobe to datapath
- `ld`  out  1  latch product into result register
- `reg_clr`  out  1  clear result register
- `display`  out  1  seven-segment enable
- `busy`  out  1  multiplication in progress
- `done`  out  1  one-cycle pulse, result valid
- `iter`  out  $clog2(N_BITS)  current iteration index k

## Operation
- Buttons are rising-edge detected (registered) to get start_p, clear_p and abort_p. A level held high generates exactly one pulse.
- Pulse priority: abort > start > clear.
- States: IDLE, LOAD, CLEAR, EXEC, SHIFT, LATCH, SHOW, WIPE.
- IDLE: start_p moves to LOAD. clear_p and abort_p are ignored.
- LOAD: load_inputs=1, then CLEAR.
- CLEAR: clr=1, k←0, then EXEC.
- EXEC: selects the datapath op from mult_bit, then SHIFT.
  - mult_bit=0: sel=00.
  - mult_bit=1 and k<N_BITS-1: sel=01.
  - mult_bit=1 and k=N_BITS-1: sel=11 (two's-complement sign weight).
- SHIFT: sel=10, inc=1.
  - If k=N_BITS-1, go to LATCH.
  - Otherwise k←k+1 and return to EXEC.
- LATCH: ld=1, then SHOW.
- SHOW: display=1; done=1 on the first SHOW cycle only.
  - The hold counter starts at 0 on SHOW entry and saturates at HOLD_CYCLES.
  - clear_p is ignored while the counter is below HOLD_CYCLES. Once it reaches HOLD_CYCLES, clear_p moves to WIPE.
  - start_p is ignored in SHOW.
- WIPE: reg_clr=1, display=0, then IDLE.
- abort_p in LOAD, CLEAR, EXEC, SHIFT, LATCH or SHOW goes to WIPE on the next edge. The abort cycle itself still drives that state's outputs.
- busy=1 in LOAD through LATCH.
- iter=k in EXEC/SHIFT; iter=0 elsewhere.
- All outputs are combinational decodes of the registered state plus mult_bit. No other output depends combinationally on inputs.

## Timing
- Reset: state=IDLE, k=0, hold counter=0, edge-detector history=0. All outputs 0.
- Reset mid-operation aborts with no WIPE cycle; reg_clr stays 0. The datapath is reset by the same `reset`.
- Cycle 0 = first cycle start_p is high while in IDLE. start_p is high the cycle after button[0] is first sampled high.
- Cycle 1: LOAD. Cycle 2: CLEAR.
- For k=0..N_BITS-1: EXEC at 3+2k, SHIFT at 4+2k.
- Cycle 3+2N_BITS: LATCH (cycle 19 for N_BITS=8).
- Cycle 4+2N_BITS: SHOW entry and done pulse. display stays high from this cycle.
- busy is high for cycles 1..3+2N_BITS.
- Earliest accepted clear_p: cycle 4+2N_BITS+HOLD_CYCLES. WIPE is the next cycle; IDLE follows one cycle later.
- mult_bit is sampled in the EXEC cycle. The datapath updates it on the SHIFT edge.

## Structure
- Package `mul_seq_pkg`:
  - state enum `mul_state_t`
  - sel encodings `SEL_HOLD`, `SEL_ADD`, `SEL_SHIFT`, `SEL_SUB`
  - button index constants `BTN_START`, `BTN_CLEAR`, `BTN_ABORT`
- Sub-module `btn_edge`: 4-bit registered rising-edge detector with synchronous reset, instantiated once.
- Main module holds the FSM, the iteration counter and the hold counter.

## Test plan
- B=3 (mult_bit sequence 1,1,0,0,0,0,0,0), start:
  - load_inputs at cycle 1, clr at 2
  - sel=01 at cycles 3 and 5, sel=00 at 7..17 odd
  - sel=10 and inc at even cycles 4..18
  - ld at 19, done and display at 20
- B=−2 (0xFE, bits 0,1,1,1,1,1,1,1): sel=00 at k=0, 01 at k=1..6, 11 at k=7 (cycle 17).
- HOLD_CYCLES=4:
  - clear_p at cycle 22 is ignored (display stays 1)
  - clear_p at cycle 24 gives reg_clr=1 at 25 and IDLE at 26
  - button held high 10 cycles gives a single pulse
- abort_p at cycle 9 (EXEC, k=3): WIPE at cycle 10 (reg_clr=1), IDLE at 11, no ld, no done.
- start_p and abort_p together in SHOW: WIPE. start_p during busy: ignored, timing unchanged.
- reset asserted at cycle 12: all outputs 0 next cycle. A fresh start after release reproduces the first scenario's timing exactly.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// mul_seq_pkg: shared state, datapath-op and button encodings for the shift-add
// multiplier sequencer.
package mul_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_EXEC, S_SHIFT, S_LATCH, S_SHOW, S_WIPE
    } mul_state_t;
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_ADD   = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam logic [1:0] SEL_SUB   = 2'b11;
    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_ABORT = 3;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_seq_if: button/datapath/display signals of the multiplier sequencer.
// master = sequencer side, slave = buttons + datapath + display side.
interface mul_seq_if #(parameter int N_BITS = 8);
    localparam int KW = $clog2(N_BITS);
    logic [3:0]    button;
    logic          mult_bit;
    logic          load_inputs;
    logic          clr;
    logic [1:0]    sel;
    logic          inc;
    logic          ld;
    logic          reg_clr;
    logic          display;
    logic          busy;
    logic          done;
    logic [KW-1:0] iter;
    modport master (
        input  button, mult_bit,
        output load_inputs, clr, sel, inc, ld, reg_clr, display, busy, done, iter
    );
    modport slave (
        output button, mult_bit,
        input  load_inputs, clr, sel, inc, ld, reg_clr, display, busy, done, iter
    );
endinterface

// File: rtl/mul_sequencer_btn_edge.sv
// btn_edge: registered rising-edge detector; a held level yields one pulse,
// one cycle after the first high sample.
module btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_i,
    output logic [3:0] pulse_o
);
    logic [3:0] prev_q, pulse_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= btn_i;
            pulse_q <= btn_i & ~prev_q;
        end
    end
    assign pulse_o = pulse_q;
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: control FSM for the signed shift-add multiplier; one EXEC/SHIFT
// pair per multiplier bit, then holds the result on the display before clear.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int HOLD_CYCLES = 200
) (
    input logic      clk,
    input logic      reset,
    mul_seq_if.master bus
);
    localparam int KW = $clog2(N_BITS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_BITS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);

    mul_state_t    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    pulse;
    logic          start_p, clear_p, abort_p, k_last, abortable, unused_btn;

    btn_edge u_edge (.clk(clk), .reset(reset), .btn_i(bus.button), .pulse_o(pulse));

    assign start_p    = pulse[BTN_START];
    assign clear_p    = pulse[BTN_CLEAR];
    assign abort_p    = pulse[BTN_ABORT];
    assign unused_btn = pulse[2];
    assign k_last     = k_q == K_LAST;
    assign abortable  = state_q inside {S_LOAD, S_CLEAR, S_EXEC, S_SHIFT, S_LATCH, S_SHOW};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_p ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_CLEAR;
            S_CLEAR: state_d = S_EXEC;
            S_EXEC:  state_d = S_SHIFT;
            S_SHIFT: state_d = k_last ? S_LATCH : S_EXEC;
            S_LATCH: state_d = S_SHOW;
            S_SHOW:  state_d = (clear_p && hold_q == H_MAX) ? S_WIPE : S_SHOW;
            default: state_d = S_IDLE;
        endcase
        if (abort_p && abortable) state_d = S_WIPE;
    end

    assign k_d = (state_q == S_CLEAR) ? '0 :
                 (state_q == S_SHIFT && !k_last) ? k_q + KW'(1) : k_q;
    // Hold counter is zero outside SHOW, so SHOW always starts counting from 0.
    assign hold_d = (state_q != S_SHOW) ? '0 :
                    (hold_q == H_MAX) ? hold_q : hold_q + HW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.load_inputs = state_q == S_LOAD;
    assign bus.clr         = state_q == S_CLEAR;
    assign bus.inc         = state_q == S_SHIFT;
    assign bus.ld          = state_q == S_LATCH;
    assign bus.reg_clr     = state_q == S_WIPE;
    assign bus.display     = state_q == S_SHOW;
    assign bus.done        = state_q == S_SHOW && hold_q == '0;
    assign bus.busy        = state_q inside {S_LOAD, S_CLEAR, S_EXEC, S_SHIFT, S_LATCH};
    assign bus.iter        = (state_q == S_EXEC || state_q == S_SHIFT) ? k_q : '0;
    // The top multiplier bit carries negative weight, hence subtract on the last step.
    assign bus.sel = (state_q == S_SHIFT) ? SEL_SHIFT :
                     (state_q == S_EXEC && bus.mult_bit) ? (k_last ? SEL_SUB : SEL_ADD) :
                     SEL_HOLD;
endmodule
